fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling buffer directly downstream of the PC/instruction-ROM fetch stage.
- Captures each fetched instruction word with its PC and presents it to decode through a valid/ready handshake.
- Absorbs decode stalls without losing fetched words; a branch/jump redirect clears it via flush.
- Sits between the fetch top level and the decode stage.

Parameters:
- ADDRESS_WIDTH, 32, width of PC values.
- DATA_WIDTH, 32, width of instruction words.
- DEPTH, 2, number of entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  fetch presents a word this cycle.
- in_ready  output  1  queue can accept a word this cycle.
- instr_i  input  DATA_WIDTH  fetched instruction.
- pc_i  input  ADDRESS_WIDTH  PC of instr_i.
- flush  input  1  discard all held entries and the current input (redirect).
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- instr_o  output  DATA_WIDTH  head instruction; NOP when empty.
- pc_o  output  ADDRESS_WIDTH  head PC; 0 when empty.
- pc_plus4_o  output  ADDRESS_WIDTH  pc_o + 4; 0 when empty.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- State: storage array [DEPTH], write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset (async, any cycle, including mid-transfer):
  - count, pointers = 0.
  - out_valid = 0, instr_o = NOP (32'h00000013), pc_o = 0, pc_plus4_o = 0, occupancy = 0.
  - in_ready = 1 once rst deasserts.
- in_ready = (count != DEPTH). It depends only on registered state; no combinational path from out_ready.
- out_valid = (count != 0).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push: write {instr_i, pc_i} at the write pointer, then increment it.
- Pop: increment the read pointer.
- count: +1 on push only; −1 on pop only; unchanged on simultaneous push and pop.
- Latency:
  - A word pushed at edge N is visible on the outputs after edge N, not in the same cycle. There is no bypass path.
  - Back-to-back throughput is 1 word/cycle with simultaneous push and pop.
- Full (count == DEPTH): in_ready = 0 even if out_ready = 1 that cycle; a pop frees a slot for the next cycle.
- Empty: out_valid = 0 and outputs take the empty values; out_ready is ignored.
- Flush (synchronous, highest priority after rst):
  - At the next edge: count = 0, pointers = 0.
  - Both push and pop are suppressed in the flush cycle, so an in_valid word offered that cycle is dropped.
  - Outputs are empty from the following cycle.
- Head outputs:
  - instr_o and pc_o come from storage at the read pointer, muxed to the empty values when count == 0.
  - pc_plus4_o = pc_o + 4, truncated to ADDRESS_WIDTH (0xFFFFFFFC → 0x00000000).
- occupancy = count.
- Held data is stable while out_valid = 1 and out_ready = 0.

Decomposition:
- fetch_pkg holds:
  - localparam NOP_INSTR = 32'h00000013.
  - typedef fetch_entry_t: packed struct {instr, pc}, sized by the package widths.
- No sub-module: storage, pointers and count are implemented inline.
- The fetch top level instantiates fetch_queue after its ROM output.

Test Plan:
- Reset: assert rst mid-operation with count = 2 → immediately out_valid = 0, instr_o = 0x00000013, pc_o = 0, occupancy = 0; after deassert, in_ready = 1.
- Single word: push instr 0x00500093, pc 0x00000000 with out_ready = 0 → next cycle out_valid = 1, instr_o = 0x00500093, pc_plus4_o = 0x00000004, occupancy = 1.
- Full/stall: push pc 0x0, 0x4, 0x8 consecutively with out_ready = 0 → in_ready drops after the second push; the 0x8 word is not accepted and occupancy stays 2. Raise out_ready → pops 0x0 then 0x4 in order; in_ready returns the cycle after the first pop.
- Streaming: in_valid and out_ready held high for 8 cycles with pc = 0x10 + 4k → outputs appear one cycle behind with no gaps, occupancy constant at 1, no reordering.
- Flush: occupancy 2, assert flush with in_valid = 1 (pc 0x20) and out_ready = 1 → next cycle occupancy = 0, out_valid = 0, and the 0x20 word is never output.
- Wrap: head pc 0xFFFFFFFC → pc_plus4_o = 0x00000000. Run 5 push/pop pairs → pointers wrap with data intact.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: default widths, the NOP encoding and
// the entry layout that travels from the instruction ROM to decode.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling queue between instruction fetch and decode: buffers {instr, pc}
// pairs behind a valid/ready handshake and is cleared by a redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = FETCH_ADDR_W,
  parameter int unsigned DATA_WIDTH    = FETCH_DATA_W,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      instr_i,
  input  logic [ADDRESS_WIDTH-1:0]   pc_i,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      instr_o,
  output logic [ADDRESS_WIDTH-1:0]   pc_o,
  output logic [ADDRESS_WIDTH-1:0]   pc_plus4_o,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0]    instr_mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // in_ready is a function of registered count only, so decode back-pressure
  // never forms a combinational path into the fetch stage.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the empty mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_i;
    end
  end

  always_comb begin
    instr_o    = DATA_WIDTH'(NOP_INSTR);
    pc_o       = '0;
    pc_plus4_o = '0;
    if (out_valid) begin
      instr_o    = instr_mem_q[rd_ptr_q];
      pc_o       = pc_mem_q[rd_ptr_q];
      pc_plus4_o = pc_mem_q[rd_ptr_q] + ADDRESS_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [1:0]  occupancy;

  fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT against the model, then advances the model by the
  // handshake rules for the edge that follows.
  always @(negedge clk) begin
    if (!rst) begin
      automatic logic exp_rdy = (exp_q.size() < DEPTH);
      automatic logic exp_vld = (exp_q.size() != 0);
      chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
      chk("occupancy", {30'b0, occupancy}, exp_q.size());
      if (exp_vld) begin
        chk("instr_o",    instr_o,    exp_q[0].instr);
        chk("pc_o",       pc_o,       exp_q[0].pc);
        chk("pc_plus4_o", pc_plus4_o, exp_q[0].pc + 32'd4);
      end else begin
        chk("instr_o_empty",    instr_o,    NOP);
        chk("pc_o_empty",       pc_o,       32'h0);
        chk("pc_plus4_o_empty", pc_plus4_o, 32'h0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_vld && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) exp_q.push_back('{instr: instr_i, pc: pc_i});
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    instr_i   = ins;
    pc_i      = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, $urandom, $urandom, ordy, 1'b0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // single word
    drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // full / stall, then ordered drain
    drive(1'b1, 32'h11111111, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h22222222, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h33333333, 32'h8, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // streaming
    for (int k = 0; k < 8; k++) drive(1'b1, $urandom, 32'h10 + 32'(4 * k), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // flush with a word on the input
    drive(1'b1, 32'hAAAA0001, 32'h100, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0002, 32'h104, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD0020, 32'h20, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // wrap of pc_plus4 and of the pointers
    drive(1'b1, 32'hCAFE0001, 32'hFFFFFFFC, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 5; k++) drive(1'b1, $urandom, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // async reset mid-operation with two entries held
    drive(1'b1, 32'hBEEF0001, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'hBEEF0002, 32'h304, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr_o",   instr_o,            NOP);
    chk("rst_pc_o",      pc_o,               32'h0);
    chk("rst_pc_plus4",  pc_plus4_o,         32'h0);
    chk("rst_occupancy", {30'b0, occupancy}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      automatic logic [31:0] pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC
                                                               : ($urandom & 32'hFFFFFFFC);
      drive(($urandom_range(0, 3) != 0), $urandom, pc,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
